ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port 64-entry distributed RAM in primitive_example_design_1 between two requesters (port 0, port 1) using round-robin arbitration.
- Drives the RAM's ram_addr, ram_we and write data, and routes read data back to the granting requester.
- After reset, and on demand, it scrubs the whole RAM to zero before accepting traffic.
- Sits between the design's control logic and the RAM primitive; one access per clock at full throughput.

Parameters:
ADDR_W, 6, RAM address width; depth = 2**ADDR_W
DATA_W, 8, RAM data width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req  input  2  per-port access request (bit i = port i)
req_we  input  2  per-port write (1) / read (0) qualifier, valid with req
req_addr  input  2*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
req_wdata  input  2*DATA_W  per-port write data, port i at [i*DATA_W +: DATA_W]
gnt  output  2  combinational accept; transfer occurs when req[i] & gnt[i]
rd_valid  output  2  one-cycle pulse: rd_data belongs to port i
rd_data  output  DATA_W  read data, valid only while a rd_valid bit is high
clear  input  1  request re-scrub of RAM (level, sampled in RUN)
init_done  output  1  high when scrub complete and arbiter in RUN
ram_addr  output  ADDR_W  RAM address (registered)
ram_we  output  1  RAM write enable (registered)
ram_wdata  output  DATA_W  RAM write data (registered)
ram_rdata  input  DATA_W  RAM synchronous read data, valid 1 cycle after address

Behaviour:
- Reset values (cycle after rst high): state INIT, scrub counter 0, last_gnt=1, ram_addr=0, ram_we=0, ram_wdata=0, rd_valid=0, init_done=0. gnt=0 whenever state != RUN.
- FSM states:
  - INIT: ram_we=1, ram_addr=counter, ram_wdata=0, counter+1 each cycle. After writing address 2**ADDR_W-1 -> RUN; ram_we=0 on that transition; init_done=1 from the first RUN cycle.
  - RUN: arbitration active.
    - clear=1 with a read issued last cycle -> DRAIN.
    - clear=1 with no read issued last cycle -> INIT. Counter reset to 0, init_done=0 next cycle.
  - DRAIN: gnt=0; the outstanding rd_valid is delivered; next cycle -> INIT.
- While clear=1 in RUN, gnt=0 (no new accepts).
- Arbitration (RUN, combinational):
  - Single requester is granted.
  - If both request, the port != last_gnt is granted.
  - last_gnt updates to the granted port on transfer; it is unchanged when nothing transfers.
  - Exactly one gnt bit at most.
- Issue timing:
  - A transfer in cycle N registers ram_addr/ram_we/ram_wdata for cycle N+1. ram_we=1 only for accepted writes, otherwise 0.
  - ram_addr holds its last value when idle.
- Read return: an accepted read in cycle N gives rd_valid[port]=1 in cycle N+2, with rd_data = ram_rdata passthrough.
  - Reads pipeline back-to-back; a port-tagged shift register of depth 2 tracks them.
- Ordering: a write in cycle N followed by a read of the same address in N+1 returns the new data (RAM write-first ordering preserved by issue order).
- A requester holds req/req_we/req_addr/req_wdata stable until gnt; dropping req without gnt is legal (no access issued).
- rst mid-operation: in-flight reads discarded (no rd_valid), scrub restarts from 0.
- clear during INIT: ignored.
- Latency: scrub is 2**ADDR_W cycles (64 default); arbitration is 0 cycles; read return is 2 cycles.

Decomposition:
- Package ram_arb_pkg: state enum (INIT, RUN, DRAIN), NUM_PORTS=2 constant, default ADDR_W/DATA_W.
- One sub-module rr_arb2: combinational 2-way round-robin grant plus last_gnt register. Its inputs are req, en and a transfer strobe; its output is gnt.

Test Plan:
1. Reset release, no requests -> ram_we=1 for exactly 64 cycles, ram_addr 0..63, ram_wdata=0; init_done=1 on cycle 65; gnt stays 0 until then.
2. Port 0 write addr 5 data 0xA5, next cycle port 0 read addr 5 -> ram_we pulse with addr 5; rd_valid=2'b01 two cycles after the read transfer, rd_data=0xA5.
3. Both ports request reads continuously (p0 addr 1, p1 addr 2) -> gnt alternates 01,10,01,... starting with port 0; rd_valid alternates accordingly, one per cycle.
4. Read of untouched addr 63 after scrub -> rd_data=0x00.
5. Port 1 read accepted, clear asserted next cycle -> state DRAIN; rd_valid=2'b10 still delivered; then 64-cycle scrub; init_done low during it; prior data at addr 5 reads 0x00 afterward.
6. rst asserted one cycle after read accepted -> no rd_valid pulse; all outputs at reset values; scrub restarts at addr 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned NUM_PORTS  = 2;
    localparam int unsigned DEF_ADDR_W = 6;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-granted port.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       xfer,
    output logic [1:0] gnt
);

    logic last_gnt_q;

    // Grant a lone requester; on contention favour the port not granted last.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Remember the winner only when a transfer actually happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else if (xfer) begin
            last_gnt_q <= gnt[1];
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a single-port synchronous RAM between two requesters, scrubbing it to zero
// after reset and on clear. Reads return two cycles after acceptance.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          gnt,
    output logic [NUM_PORTS-1:0]          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    input  logic                          clear,
    output logic                          init_done,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic                          ram_we,
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic [DATA_W-1:0]             ram_rdata
);

    state_e              state_q;
    // Extra MSB flags that the last address has been issued.
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic                ram_we_q;
    logic [DATA_W-1:0]   ram_wdata_q;
    logic                init_done_q;
    // Two-stage read tracker: s1 = address at RAM, s2 = data at RAM output.
    logic                s1_valid_q, s1_port_q;
    logic                s2_valid_q, s2_port_q;

    logic [1:0]          gnt_w;
    logic                arb_en;
    logic                xfer;
    logic                sel;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    assign arb_en = (state_q == StRun) && !clear;
    assign xfer   = |(req & gnt_w);

    // Mux the granted port's request onto the issue path.
    always_comb begin
        sel       = gnt_w[1];
        sel_we    = sel ? req_we[1] : req_we[0];
        sel_addr  = sel ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
        sel_wdata = sel ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    end

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .en   (arb_en),
        .xfer (xfer),
        .gnt  (gnt_w)
    );

    // Control FSM with registered RAM-side outputs and read-return tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            init_done_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_port_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_port_q   <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_port_q  <= s1_port_q;
            s1_valid_q <= 1'b0;
            ram_we_q   <= 1'b0;
            case (state_q)
                StInit: begin
                    if (cnt_q[ADDR_W]) begin
                        state_q     <= StRun;
                        init_done_q <= 1'b1;
                    end else begin
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= cnt_q[ADDR_W-1:0];
                        ram_wdata_q <= '0;
                        cnt_q       <= cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (clear) begin
                        // A read issued last cycle still owes its rd_valid.
                        state_q     <= s1_valid_q ? StDrain : StInit;
                        init_done_q <= 1'b0;
                        cnt_q       <= '0;
                    end else if (xfer) begin
                        ram_we_q    <= sel_we;
                        ram_addr_q  <= sel_addr;
                        ram_wdata_q <= sel_wdata;
                        s1_valid_q  <= !sel_we;
                        s1_port_q   <= sel;
                    end
                end
                StDrain: begin
                    state_q <= StInit;
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

    assign gnt       = gnt_w;
    assign rd_valid  = {s2_valid_q & s2_port_q, s2_valid_q & ~s2_port_q};
    assign rd_data   = ram_rdata;
    assign init_done = init_done_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural RAM and read scoreboard.
module tb_ram_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      gnt;
    logic [1:0]      rd_valid;
    logic [DW-1:0]   rd_data;
    logic            clear;
    logic            init_done;
    logic [AW-1:0]   ram_addr;
    logic            ram_we;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;
    logic            tb_fill;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .clear     (clear),
        .init_done (init_done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Behavioural single-port synchronous RAM, pre-filled with non-zero junk.
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        if (tb_fill) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
    end

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] sh [64];
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample at negedge: record accepted transfers, score any returning read.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (req[i] && gnt[i]) begin
                if (req_we[i]) begin
                    sh[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
                end else begin
                    e.port = i[0];
                    e.data = sh[req_addr[i*AW +: AW]];
                    exp_q.push_back(e);
                end
            end
        end
        if (rd_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rd_port", 32'(rd_valid), e.port ? 32'd2 : 32'd1);
                check("rd_data", 32'(rd_data), 32'(e.data));
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        req[p]              = 1'b1;
        req_we[p]           = we;
        req_addr[p*AW +: AW] = a;
        req_wdata[p*DW +: DW] = d;
    endtask

    task automatic zero_shadow();
        for (int i = 0; i < 64; i++) sh[i] = '0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            sample();
            adv();
        end
    endtask

    task automatic access(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        bit got_it = 1'b0;
        set_port(p, we, a, d);
        for (int k = 0; k < 20; k++) begin
            sample();
            if (gnt[p]) begin
                got_it = 1'b1;
                break;
            end
            adv();
        end
        check("acc_gnt", 32'(got_it), 32'd1);
        adv();
        req[p] = 1'b0;
    endtask

    // Follow a scrub to completion; returns at the negedge of the first RUN cycle.
    task automatic wait_init();
        int cnt  = 0;
        bit seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            sample();
            if (init_done) begin
                seen = 1'b1;
                break;
            end
            if (ram_we) begin
                check("scrub_addr", 32'(ram_addr), 32'(cnt));
                check("scrub_wdata", 32'(ram_wdata), 32'd0);
                cnt++;
            end
            check("scrub_gnt", 32'(gnt), 32'd0);
            adv();
        end
        check("init_seen", 32'(seen), 32'd1);
        check("scrub_len", 32'(cnt), 32'd64);
        check("done_we", 32'(ram_we), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        tb_fill   = 1'b1;
        zero_shadow();
        adv();
        tb_fill = 1'b0;
        adv();

        // Reset values, with requests present to show gnt is held off.
        req = 2'b11;
        sample();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        check("rst_rdv", 32'(rd_valid), 32'd0);
        check("rst_done", 32'(init_done), 32'd0);
        adv();
        req = '0;
        rst = 1'b0;

        // 1: initial scrub.
        wait_init();
        adv();

        // 2: write then read-back on port 0.
        set_port(0, 1'b1, 6'd5, 8'hA5);
        sample();
        check("t2_wgnt", 32'(gnt), 32'd1);
        adv();
        set_port(0, 1'b0, 6'd5, 8'h00);
        sample();
        check("t2_we", 32'(ram_we), 32'd1);
        check("t2_addr", 32'(ram_addr), 32'd5);
        check("t2_wdata", 32'(ram_wdata), 32'hA5);
        check("t2_rgnt", 32'(gnt), 32'd1);
        adv();
        req = '0;
        sample();
        check("t2_rd_we", 32'(ram_we), 32'd0);
        check("t2_rd_addr", 32'(ram_addr), 32'd5);
        adv();
        sample();
        check("t2_rdv", 32'(rd_valid), 32'd1);
        adv();

        // Seed addresses used by the alternation test.
        access(0, 1'b1, 6'd1, 8'h11);
        access(1, 1'b1, 6'd2, 8'h22);

        // 4: untouched address reads as scrubbed zero; leaves last grant on port 1.
        access(1, 1'b0, 6'd63, 8'h00);
        drain(3);

        // 3: continuous contention alternates, starting with port 0.
        set_port(0, 1'b0, 6'd1, 8'h00);
        set_port(1, 1'b0, 6'd2, 8'h00);
        for (int k = 0; k < 8; k++) begin
            sample();
            check("t3_gnt", 32'(gnt), (k % 2) ? 32'd2 : 32'd1);
            if (k >= 2) check("t3_rdv", 32'(rd_valid), (k % 2) ? 32'd2 : 32'd1);
            adv();
        end
        req = '0;
        sample();
        check("t3_rdv_tail0", 32'(rd_valid), 32'd1);
        adv();
        sample();
        check("t3_rdv_tail1", 32'(rd_valid), 32'd2);
        adv();
        drain(2);

        // 5: read on port 1, clear next cycle -> drain, re-scrub.
        set_port(1, 1'b0, 6'd5, 8'h00);
        sample();
        check("t5_gnt", 32'(gnt), 32'd2);
        adv();
        set_port(0, 1'b0, 6'd5, 8'h00);
        clear = 1'b1;
        sample();
        check("t5_clr_gnt", 32'(gnt), 32'd0);
        adv();
        clear = 1'b0;
        sample();
        check("t5_drain_rdv", 32'(rd_valid), 32'd2);
        check("t5_drain_done", 32'(init_done), 32'd0);
        check("t5_drain_gnt", 32'(gnt), 32'd0);
        adv();
        zero_shadow();
        wait_init();
        check("t5_first_gnt", 32'(gnt), 32'd1);
        adv();
        req[0] = 1'b0;
        sample();
        check("t5_second_gnt", 32'(gnt), 32'd2);
        adv();
        req = '0;
        drain(3);

        // 6: reset one cycle after a read is accepted -> no return, scrub restarts.
        set_port(0, 1'b0, 6'd1, 8'h00);
        sample();
        check("t6_gnt", 32'(gnt), 32'd1);
        adv();
        req = '0;
        rst = 1'b1;
        exp_q.delete();
        sample();
        adv();
        req = 2'b11;
        sample();
        check("t6_rdv", 32'(rd_valid), 32'd0);
        check("t6_we", 32'(ram_we), 32'd0);
        check("t6_addr", 32'(ram_addr), 32'd0);
        check("t6_wdata", 32'(ram_wdata), 32'd0);
        check("t6_done", 32'(init_done), 32'd0);
        check("t6_rst_gnt", 32'(gnt), 32'd0);
        adv();
        req = '0;
        rst = 1'b0;
        zero_shadow();
        wait_init();
        adv();
        set_port(0, 1'b0, 6'd0, 8'h00);
        set_port(1, 1'b0, 6'd0, 8'h00);
        sample();
        check("t6_lastgnt", 32'(gnt), 32'd1);
        adv();
        req = '0;
        drain(4);

        check("q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
